pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline.
- Drives stall/flush on the IF/ID and ID/EX registers, the PC-enable stall, and a back-end hold.
- Detects load-use hazards, branch mispredicts resolved in EX, data-memory wait and ID-stage fence drains.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
- CNT_W, 16, width of performance counters.
- DRAIN_CYCLES, 3, front-end stall cycles for a fence (EX, MEM and WB drain); range 1..15.
- TIMEOUT, 255, consecutive mem_busy cycles before mem_timeout is set; range 1..(2^16)-1.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1_addr  in  5  rs1 of the instruction in ID
- id_rs2_addr  in  5  rs2 of the instruction in ID
- id_uses_rs2  in  1  instruction in ID reads rs2
- id_fence  in  1  instruction in ID is a fence
- ex_rd_addr  in  5  rd of the instruction in EX
- ex_mem_rd  in  1  instruction in EX is a load
- ex_branch  in  1  instruction in EX is a branch
- ex_prediction  in  1  predicted-taken bit carried with the EX branch
- ex_taken  in  1  actual branch outcome from EX
- mem_busy  in  1  data memory not ready this cycle
- pc_stall  out  1  hold the PC
- if_id_stall  out  1  hold the IF/ID register
- if_id_flush  out  1  clear the IF/ID register
- id_ex_flush  out  1  insert a bubble into ID/EX
- be_hold  out  1  hold the EX/MEM and MEM/WB registers
- redirect  out  1  select the corrected PC (mispredict)
- mem_timeout  out  1  sticky memory-timeout error
- stall_cnt  out  CNT_W  cycles with pc_stall=1
- flush_cnt  out  CNT_W  cycles with if_id_flush=1

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State=RUN; drain and timeout counters cleared.
  - mem_timeout=0, stall_cnt=0, flush_cnt=0.
  - All combinational outputs read 0 while rst_n=0.
- Hazard terms:
  - mispredict = ex_branch & (ex_prediction != ex_taken).
  - load_use = ex_mem_rd & (ex_rd_addr!=0) & ((ex_rd_addr==id_rs1_addr) | (id_uses_rs2 & ex_rd_addr==id_rs2_addr)).
- All control outputs are combinational from the current state and inputs, so they act in the same cycle.
- State machine: RUN, HOLD, DRAIN.
- RUN, priority is mem_busy > mispredict > load_use > id_fence:
  - mem_busy: pc_stall=if_id_stall=be_hold=1, no flushes. Next state HOLD; timeout counter loads 1.
  - mispredict: redirect=if_id_flush=id_ex_flush=1, pc_stall=0. Stay in RUN.
  - load_use: pc_stall=if_id_stall=id_ex_flush=1, for exactly 1 cycle. The next cycle the load is in MEM, so load_use is naturally 0.
  - id_fence: pc_stall=if_id_stall=id_ex_flush=1. Next state DRAIN; drain counter loads DRAIN_CYCLES-1.
  - otherwise: all outputs 0.
- HOLD:
  - While mem_busy: pc_stall=if_id_stall=be_hold=1. Timeout counter increments, saturating.
  - When the count reaches TIMEOUT, mem_timeout sets; it clears only on reset.
  - mem_busy=0: behave exactly as RUN for this cycle and apply the RUN next-state rules.
  - A mispredict is never acted on while held. The branch stays in EX and is resolved in the first non-busy cycle.
- DRAIN:
  - Outputs pc_stall=if_id_stall=id_ex_flush=1; decrement the drain counter; return to RUN when it is 0. Total stall = DRAIN_CYCLES cycles including the RUN entry cycle.
  - mem_busy in DRAIN: additionally assert be_hold; the drain counter freezes.
  - mispredict in DRAIN (older branch in EX): the fence is wrong-path. Apply the mispredict outputs (pc_stall=0) and go to RUN immediately.
- Counters:
  - stall_cnt +1 every cycle pc_stall=1; flush_cnt +1 every cycle if_id_flush=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset mid-operation: HOLD or DRAIN aborts to RUN, with all outputs 0 in the same cycle rst_n falls.

Test Plan:
- Load-use: ex_mem_rd=1, ex_rd_addr=5, id_rs1_addr=5 for 1 cycle → pc_stall=if_id_stall=id_ex_flush=1 that cycle only; stall_cnt=1.
- x0 and rs2-unused: ex_rd_addr=0 matching rs1 → no stall. ex_rd_addr=7=id_rs2_addr with id_uses_rs2=0 → no stall.
- Mispredict with simultaneous load_use: ex_branch=1, ex_prediction=0, ex_taken=1 → redirect=if_id_flush=id_ex_flush=1, pc_stall=0; flush_cnt=1.
- mem_busy for 4 cycles with a mispredicting branch in EX → be_hold=1 for 4 cycles, no redirect; redirect=1 on cycle 5; stall_cnt=4.
- Fence, DRAIN_CYCLES=3:
  - pc_stall=1 for exactly 3 cycles, then 0.
  - Repeat with a mispredict on drain cycle 2 → redirect that cycle, RUN the next cycle, stall total 1.
- Timeout and reset: TIMEOUT=8 with mem_busy held 10 cycles → mem_timeout=1 from cycle 8 and stays set. Pulse rst_n low mid-DRAIN → all outputs 0 immediately, counters 0, mem_timeout 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard inputs and stall/flush controls between pipeline and sequencer
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic       id_uses_rs2;
  logic       id_fence;
  logic [4:0] ex_rd_addr;
  logic       ex_mem_rd;
  logic       ex_branch;
  logic       ex_prediction;
  logic       ex_taken;
  logic       mem_busy;
  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       be_hold;
  logic       redirect;

  // Pipeline side: reports stage contents, obeys the controls
  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs2, id_fence,
    output ex_rd_addr, ex_mem_rd, ex_branch, ex_prediction, ex_taken, mem_busy,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, be_hold, redirect
  );

  // Sequencer side
  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs2, id_fence,
    input  ex_rd_addr, ex_mem_rd, ex_branch, ex_prediction, ex_taken, mem_busy,
    output pc_stall, if_id_stall, if_id_flush, id_ex_flush, be_hold, redirect
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 3,
  parameter int TIMEOUT      = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_hazard_ctrl_if.slave hz,
  output logic                 mem_timeout,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [3:0]  dcnt, dcnt_nxt;
  logic [15:0] tcnt, tcnt_nxt;
  logic        fence_pass, fence_set;
  logic        mispredict, load_use, fence_req, use_run;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush, be_hold, redirect;

  assign mispredict = hz.ex_branch & (hz.ex_prediction != hz.ex_taken);
  assign load_use   = hz.ex_mem_rd & (hz.ex_rd_addr != 5'd0) &
                      ((hz.ex_rd_addr == hz.id_rs1_addr) |
                       (hz.id_uses_rs2 & (hz.ex_rd_addr == hz.id_rs2_addr)));
  // A fence that has already drained must be let through, otherwise it re-stalls forever while held in ID
  assign fence_req  = hz.id_fence & ~fence_pass;

  // Consecutive mem_busy cycles, saturating; cleared by any ready cycle
  assign tcnt_nxt = !hz.mem_busy ? 16'd0 : ((tcnt == 16'hFFFF) ? tcnt : tcnt + 16'd1);

  // Control outputs and next state from current state and hazard terms
  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    be_hold     = 1'b0;
    redirect    = 1'b0;
    state_nxt   = state;
    dcnt_nxt    = dcnt;
    fence_set   = 1'b0;
    use_run     = 1'b0;
    if (rst_n) begin
      case (state)
        S_DRAIN: begin
          if (hz.mem_busy) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            be_hold     = 1'b1;
          end else if (mispredict) begin
            redirect    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt   = S_RUN;
          end else begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            if (dcnt <= 4'd1) begin
              state_nxt = S_RUN;
              fence_set = 1'b1;
            end else begin
              dcnt_nxt = dcnt - 4'd1;
            end
          end
        end
        S_HOLD: begin
          if (hz.mem_busy) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            be_hold     = 1'b1;
          end else begin
            use_run = 1'b1;
          end
        end
        default: use_run = 1'b1;
      endcase

      if (use_run) begin
        state_nxt = S_RUN;
        if (hz.mem_busy) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          be_hold     = 1'b1;
          state_nxt   = S_HOLD;
        end else if (mispredict) begin
          redirect    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end else if (fence_req) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          if (DRAIN_CYCLES > 1) begin
            state_nxt = S_DRAIN;
            dcnt_nxt  = 4'(DRAIN_CYCLES - 1);
          end else begin
            fence_set = 1'b1;
          end
        end
      end
    end
  end

  assign hz.pc_stall    = pc_stall;
  assign hz.if_id_stall = if_id_stall;
  assign hz.if_id_flush = if_id_flush;
  assign hz.id_ex_flush = id_ex_flush;
  assign hz.be_hold     = be_hold;
  assign hz.redirect    = redirect;

  // State, drain/timeout counters, fence release flag and sticky timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RUN;
      dcnt        <= 4'd0;
      tcnt        <= 16'd0;
      fence_pass  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      dcnt        <= dcnt_nxt;
      tcnt        <= tcnt_nxt;
      fence_pass  <= fence_set | (fence_pass & if_id_stall);
      if (tcnt_nxt == 16'(TIMEOUT)) mem_timeout <= 1'b1;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;

  // Output vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_flush, be_hold, redirect}
  localparam logic [5:0] NONE   = 6'b000000;
  localparam logic [5:0] STALL3 = 6'b110100;
  localparam logic [5:0] MISP   = 6'b001101;
  localparam logic [5:0] BUSY   = 6'b110010;
  localparam logic [5:0] DBUSY  = 6'b110110;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  int               checks = 0;
  int               failures = 0;
  logic [5:0]       exp_q[$];

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(3), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz.slave),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    hz.id_rs1_addr = 5'd0; hz.id_rs2_addr = 5'd0; hz.id_uses_rs2 = 1'b0; hz.id_fence = 1'b0;
    hz.ex_rd_addr = 5'd0; hz.ex_mem_rd = 1'b0; hz.ex_branch = 1'b0; hz.ex_prediction = 1'b0;
    hz.ex_taken = 1'b0; hz.mem_busy = 1'b0;
  endtask

  task automatic set_misp();
    hz.ex_branch = 1'b1; hz.ex_prediction = 1'b0; hz.ex_taken = 1'b1;
  endtask

  function automatic logic [5:0] outs();
    return {hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_flush, hz.be_hold, hz.redirect};
  endfunction

  // Called at a negedge with inputs already driven; compares the cycle's outputs, advances one clock
  task automatic cyc(input string tag, input logic [5:0] exp);
    exp_q.push_back(exp);
    #2;
    chk(tag, 32'(outs()), 32'(exp_q.pop_front()));
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    hz.ex_mem_rd = 1'b1; hz.ex_rd_addr = 5'd5; hz.id_rs1_addr = 5'd5; hz.mem_busy = 1'b1;
    cyc("rst_outs", NONE);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    chk("rst_timeout", 32'(mem_timeout), 0);
    do_reset();

    // Load-use on rs1
    hz.ex_mem_rd = 1'b1; hz.ex_rd_addr = 5'd5; hz.id_rs1_addr = 5'd5;
    cyc("lu_stall", STALL3);
    clr();
    cyc("lu_after", NONE);
    chk("lu_stall_cnt", 32'(stall_cnt), 1);

    // x0 never hazards; rs2 only when used
    hz.ex_mem_rd = 1'b1; hz.ex_rd_addr = 5'd0; hz.id_rs1_addr = 5'd0;
    cyc("lu_x0", NONE);
    hz.ex_rd_addr = 5'd7; hz.id_rs1_addr = 5'd3; hz.id_rs2_addr = 5'd7; hz.id_uses_rs2 = 1'b0;
    cyc("lu_rs2_unused", NONE);
    hz.id_uses_rs2 = 1'b1;
    cyc("lu_rs2_used", STALL3);

    // Mispredict outranks load-use
    clr();
    hz.ex_mem_rd = 1'b1; hz.ex_rd_addr = 5'd5; hz.id_rs1_addr = 5'd5; set_misp();
    cyc("misp_lu", MISP);
    clr();
    cyc("misp_after", NONE);
    chk("misp_flush_cnt", 32'(flush_cnt), 1);
    chk("misp_stall_cnt", 32'(stall_cnt), 2);

    // mem_busy holds a mispredicting branch until memory is ready
    do_reset();
    set_misp(); hz.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) cyc($sformatf("busy_hold%0d", i), BUSY);
    hz.mem_busy = 1'b0;
    cyc("busy_release_misp", MISP);
    clr();
    cyc("busy_idle", NONE);
    chk("busy_stall_cnt", 32'(stall_cnt), 4);
    chk("busy_flush_cnt", 32'(flush_cnt), 1);
    chk("busy_no_timeout", 32'(mem_timeout), 0);

    // Fence held in ID: three stall cycles, then it issues
    do_reset();
    hz.id_fence = 1'b1;
    cyc("fence_c1", STALL3);
    cyc("fence_c2", STALL3);
    cyc("fence_c3", STALL3);
    cyc("fence_issue", NONE);
    clr();
    cyc("fence_idle", NONE);
    chk("fence_stall_cnt", 32'(stall_cnt), 3);

    // Older branch mispredicts during drain: fence is wrong-path
    hz.id_fence = 1'b1;
    cyc("fmisp_c1", STALL3);
    set_misp();
    cyc("fmisp_c2", MISP);
    clr();
    cyc("fmisp_run", NONE);
    chk("fmisp_stall_cnt", 32'(stall_cnt), 4);

    // mem_busy during drain freezes the drain counter
    do_reset();
    hz.id_fence = 1'b1;
    cyc("fbusy_c1", STALL3);
    hz.mem_busy = 1'b1;
    cyc("fbusy_hold", DBUSY);
    hz.mem_busy = 1'b0;
    cyc("fbusy_c2", STALL3);
    cyc("fbusy_c3", STALL3);
    cyc("fbusy_issue", NONE);
    clr();
    chk("fbusy_stall_cnt", 32'(stall_cnt), 4);

    // Timeout at 8 busy cycles, sticky; stall counter saturates at 15
    do_reset();
    hz.mem_busy = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      cyc($sformatf("tmo_out%0d", k), BUSY);
      chk($sformatf("tmo_flag%0d", k), 32'(mem_timeout), (k >= 8) ? 1 : 0);
    end
    chk("stall_sat", 32'(stall_cnt), 15);
    hz.mem_busy = 1'b0;
    cyc("tmo_release", NONE);
    chk("tmo_sticky", 32'(mem_timeout), 1);
    set_misp();
    for (int k = 0; k < 17; k++) cyc($sformatf("fsat%0d", k), MISP);
    chk("flush_sat", 32'(flush_cnt), 15);
    clr();

    // Reset mid-drain clears everything immediately
    hz.id_fence = 1'b1;
    cyc("rdrain_c1", STALL3);
    #2;
    chk("rdrain_pre", 32'(outs()), 32'(STALL3));
    rst_n = 1'b0;
    #1;
    chk("rdrain_outs", 32'(outs()), 32'(NONE));
    chk("rdrain_stall_cnt", 32'(stall_cnt), 0);
    chk("rdrain_flush_cnt", 32'(flush_cnt), 0);
    chk("rdrain_timeout", 32'(mem_timeout), 0);
    @(negedge clk);
    hz.id_fence = 1'b0;
    rst_n = 1'b1;
    cyc("rdrain_run", NONE);
    hz.ex_mem_rd = 1'b1; hz.ex_rd_addr = 5'd9; hz.id_rs2_addr = 5'd9; hz.id_uses_rs2 = 1'b1;
    cyc("post_rst_lu", STALL3);
    clr();
    cyc("post_rst_idle", NONE);
    chk("post_rst_stall_cnt", 32'(stall_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
